// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control/execute block.
// Holds the control-code width and encodings, the aluop encodings and the
// sequencer state type used by alu_seq_unit.
package alu_pkg;

  localparam int unsigned CTRL_W = 4;

  // ALU control codes
  localparam logic [CTRL_W-1:0] CtrlAnd     = 4'b0000;
  localparam logic [CTRL_W-1:0] CtrlOr      = 4'b0001;
  localparam logic [CTRL_W-1:0] CtrlAdd     = 4'b0010;  // add/lw/sw/addi
  localparam logic [CTRL_W-1:0] CtrlSll     = 4'b0011;
  localparam logic [CTRL_W-1:0] CtrlSlt     = 4'b0100;
  localparam logic [CTRL_W-1:0] CtrlSltu    = 4'b0101;
  localparam logic [CTRL_W-1:0] CtrlSub     = 4'b0110;  // sub/beq
  localparam logic [CTRL_W-1:0] CtrlXor     = 4'b0111;
  localparam logic [CTRL_W-1:0] CtrlSrl     = 4'b1000;
  localparam logic [CTRL_W-1:0] CtrlJal     = 4'b1001;
  localparam logic [CTRL_W-1:0] CtrlSra     = 4'b1010;
  localparam logic [CTRL_W-1:0] CtrlRem     = 4'b1011;
  localparam logic [CTRL_W-1:0] CtrlIllegal = 4'b1100;  // reported for undefined decodes
  localparam logic [CTRL_W-1:0] CtrlDiv     = 4'b1101;
  localparam logic [CTRL_W-1:0] CtrlMul     = 4'b1110;
  localparam logic [CTRL_W-1:0] CtrlBne     = 4'b1111;

  // aluop encodings
  localparam logic [1:0] AluOpMem    = 2'b00;
  localparam logic [1:0] AluOpBranch = 2'b01;
  localparam logic [1:0] AluOpRType  = 2'b10;
  localparam logic [1:0] AluOpIType  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StMul,
    StDiv,
    StFix,
    StDone
  } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode.
// Ports:
//   aluop_i          operation class (mem/jal, branch, R-type, I-type)
//   funct7_i         instruction funct7 (only bits 5 and 0 matter)
//   funct3_i         instruction funct3
//   jump_i           selects jal when aluop_i is mem/jal
//   ctrl_o           control code (CtrlIllegal for undefined decodes)
//   illegal_o        undefined decode
//   is_multicycle_o  legal mul/div/rem needing the iterative engine
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0]        aluop_i,
  input  logic [6:0]        funct7_i,
  input  logic [2:0]        funct3_i,
  input  logic              jump_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              illegal_o,
  output logic              is_multicycle_o
);

  logic unused_funct7;
  assign unused_funct7 = ^{funct7_i[6], funct7_i[4:1]};

  always_comb begin
    ctrl_o    = CtrlIllegal;
    illegal_o = 1'b0;
    unique case (aluop_i)
      AluOpMem: ctrl_o = jump_i ? CtrlJal : CtrlAdd;
      AluOpBranch: begin
        case (funct3_i)
          3'b000:  ctrl_o = CtrlSub;
          3'b001:  ctrl_o = CtrlBne;
          default: illegal_o = 1'b1;
        endcase
      end
      AluOpRType: begin
        if (funct7_i[0]) begin
          case (funct3_i)
            3'b000:  ctrl_o = CtrlMul;
            3'b100:  ctrl_o = CtrlDiv;
            3'b110:  ctrl_o = CtrlRem;
            default: illegal_o = 1'b1;
          endcase
        end else begin
          case ({funct7_i[5], funct3_i})
            4'b0000: ctrl_o = CtrlAdd;
            4'b1000: ctrl_o = CtrlSub;
            4'b0001: ctrl_o = CtrlSll;
            4'b0010: ctrl_o = CtrlSlt;
            4'b0011: ctrl_o = CtrlSltu;
            4'b0100: ctrl_o = CtrlXor;
            4'b0101: ctrl_o = CtrlSrl;
            4'b1101: ctrl_o = CtrlSra;
            4'b0110: ctrl_o = CtrlOr;
            4'b0111: ctrl_o = CtrlAnd;
            default: illegal_o = 1'b1;
          endcase
        end
      end
      AluOpIType: begin
        // I-type ignores funct7, so 101 always decodes as a logical shift
        case (funct3_i)
          3'b000:  ctrl_o = CtrlAdd;
          3'b001:  ctrl_o = CtrlSll;
          3'b010:  ctrl_o = CtrlSlt;
          3'b011:  ctrl_o = CtrlSltu;
          3'b100:  ctrl_o = CtrlXor;
          3'b101:  ctrl_o = CtrlSrl;
          3'b110:  ctrl_o = CtrlOr;
          default: ctrl_o = CtrlAnd;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
    is_multicycle_o = !illegal_o &&
                      (ctrl_o == CtrlMul || ctrl_o == CtrlDiv || ctrl_o == CtrlRem);
  end

endmodule

// File: rtl/alu_seq_unit.sv
// ALU control decode plus registered execute stage with an iterative
// shift-add multiplier and shift-subtract divider behind a valid/ready handshake.
// Optional build macro: ALU_EARLY_OUT_EN (mul by zero, div/rem by zero and the
// signed-overflow divide finish in one cycle instead of XLEN+1).
// Ports:
//   clk_i, reset_i             clock, synchronous active-high reset
//   in_valid_i / in_ready_o    operation handshake (ready only in idle)
//   aluop_i, funct7_i,
//   funct3_i, jump_i           decode inputs
//   src_a_i, src_b_i           operands (src_a_i is pc for jal)
//   out_valid_o / out_ready_i  result handshake, result held until consumed
//   result_o, alu_ctrl_o       registered result and control code
//   zero_o, branch_taken_o,
//   illegal_o                  flags, all low while out_valid_o is low
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        aluop_i,
  input  logic [6:0]        funct7_i,
  input  logic [2:0]        funct3_i,
  input  logic              jump_i,
  input  logic [XLEN-1:0]   src_a_i,
  input  logic [XLEN-1:0]   src_b_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   result_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic              zero_o,
  output logic              branch_taken_o,
  output logic              illegal_o
);

  localparam int unsigned ShW  = $clog2(XLEN);
  localparam int unsigned CntW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  logic              accept, early_out;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal, dec_multi;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              illegal_q, illegal_d, branch_q, branch_d;
  logic              a_neg_q, a_neg_d, b_neg_q, b_neg_d, b_zero_q, b_zero_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   exec_res, rem_sub;
  logic [XLEN:0]     rem_sh;
  logic              div_geq;
  logic [ShW-1:0]    shamt;

  alu_ctrl_decode u_decode (
    .aluop_i         (aluop_i),
    .funct7_i        (funct7_i),
    .funct3_i        (funct3_i),
    .jump_i          (jump_i),
    .ctrl_o          (dec_ctrl),
    .illegal_o       (dec_illegal),
    .is_multicycle_o (dec_multi)
  );

  assign accept = in_valid_i && in_ready_o;

`ifdef ALU_EARLY_OUT_EN
  assign early_out = dec_multi &&
                     ((dec_ctrl == CtrlMul) ? (src_a_i == '0 || src_b_i == '0)
                                            : (src_b_i == '0 ||
                                               (src_a_i == MinVal && src_b_i == '1)));
`else
  assign early_out = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (dec_multi && !early_out) state_d = (dec_ctrl == CtrlMul) ? StMul : StDiv;
          else                         state_d = StExec;
        end
      end
      StExec:       state_d = StDone;
      StMul, StDiv: if (cnt_q == CntW'(1)) state_d = StFix;
      StFix:        state_d = StDone;
      StDone:       if (out_ready_i) state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready_o     = (state_q == StIdle) && !reset_i;
    out_valid_o    = (state_q == StDone);
    result_o       = result_q;
    alu_ctrl_o     = ctrl_q;
    zero_o         = out_valid_o && (result_q == '0);
    illegal_o      = out_valid_o && illegal_q;
    branch_taken_o = 1'b0;
    // beq shares its code with sub, so the branch class is tracked separately
    if (out_valid_o && branch_q && !illegal_q) begin
      branch_taken_o = (ctrl_q == CtrlBne) ? !zero_o : zero_o;
    end
  end

  // Single-cycle result; mul/div/rem codes only reach here via early-out
  assign shamt = b_q[ShW-1:0];
  always_comb begin
    exec_res = '0;
    case (ctrl_q)
      CtrlAnd:  exec_res = a_q & b_q;
      CtrlOr:   exec_res = a_q | b_q;
      CtrlAdd:  exec_res = a_q + b_q;
      CtrlSll:  exec_res = a_q << shamt;
      CtrlSlt:  exec_res = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      CtrlSltu: exec_res = {{(XLEN-1){1'b0}}, a_q < b_q};
      CtrlSub:  exec_res = a_q - b_q;
      CtrlXor:  exec_res = a_q ^ b_q;
      CtrlSrl:  exec_res = a_q >> shamt;
      CtrlJal:  exec_res = a_q + XLEN'(4);
      CtrlSra:  exec_res = $signed(a_q) >>> shamt;
      CtrlBne:  exec_res = a_q - b_q;
      CtrlMul:  exec_res = '0;
      CtrlDiv:  exec_res = (b_q == '0) ? '1 : MinVal;
      CtrlRem:  exec_res = (b_q == '0) ? a_q : '0;
      default:  exec_res = '0;
    endcase
    if (illegal_q) exec_res = '0;
  end

  // Restoring divide step: acc_q is the partial remainder, a_q shifts the
  // dividend out of its top and the quotient bits into its bottom.
  assign rem_sh  = {acc_q, a_q[XLEN-1]};
  assign div_geq = rem_sh >= {1'b0, b_q};
  assign rem_sub = rem_sh[XLEN-1:0] - b_q;

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ctrl_d   = ctrl_q;
    illegal_d = illegal_q;
    branch_d = branch_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    b_zero_d = b_zero_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          ctrl_d    = dec_ctrl;
          illegal_d = dec_illegal;
          branch_d  = (aluop_i == AluOpBranch);
          cnt_d     = CntW'(XLEN);
          acc_d     = '0;
          a_neg_d   = src_a_i[XLEN-1];
          b_neg_d   = src_b_i[XLEN-1];
          b_zero_d  = (src_b_i == '0);
          a_d       = src_a_i;
          b_d       = src_b_i;
          // Divider works on magnitudes; signs are restored in StFix
          if (dec_multi && dec_ctrl != CtrlMul && !early_out) begin
            if (src_a_i[XLEN-1]) a_d = '0 - src_a_i;
            if (src_b_i[XLEN-1]) b_d = '0 - src_b_i;
          end
        end
      end
      StExec: result_d = exec_res;
      StMul: begin
        acc_d = acc_q + (b_q[0] ? a_q : '0);
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CntW'(1);
      end
      StDiv: begin
        acc_d = div_geq ? rem_sub : rem_sh[XLEN-1:0];
        a_d   = {a_q[XLEN-2:0], div_geq};
        cnt_d = cnt_q - CntW'(1);
      end
      StFix: begin
        if (ctrl_q == CtrlMul) begin
          result_d = acc_q;
        end else if (ctrl_q == CtrlDiv) begin
          // Divide by zero must stay all ones regardless of dividend sign
          if (b_zero_q)               result_d = '1;
          else if (a_neg_q ^ b_neg_q) result_d = '0 - a_q;
          else                        result_d = a_q;
        end else begin
          result_d = a_neg_q ? ('0 - acc_q) : acc_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      branch_q  <= 1'b0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      b_zero_q  <= 1'b0;
      result_q  <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      branch_q  <= branch_d;
      a_neg_q   <= a_neg_d;
      b_neg_q   <= b_neg_d;
      b_zero_q  <= b_zero_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Next-generation ALU control plus execute block for the RV32-style core. It absorbs the 4-bit ALU control decode and adds a registered datapath.
- Single-cycle ops (add/sub/logic/shift/compare/branch/jal) complete in 1 cycle. Mul/div/rem run on an iterative shift-add / shift-subtract engine.
- Sits between the ID/EX register and the EX/MEM register. Uses a valid/ready handshake so the pipeline stalls while the engine is busy.

Parameters:
- XLEN, 32, datapath width (>=8, power of 2).
- CTRL_W, 4, ALU control code width.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept (state IDLE and reset low).
- aluop  in  2  00 mem/jal, 01 branch, 10 R-type, 11 I-type.
- funct7  in  7  instruction funct7 (bits 5 and 0 used).
- funct3  in  3  instruction funct3.
- jump  in  1  jal qualifier for aluop 00.
- src_a  in  XLEN  operand A / rs1 / pc for jal.
- src_b  in  XLEN  operand B / rs2 / immediate.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  downstream accepts result.
- result  out  XLEN  registered result.
- alu_ctrl  out  CTRL_W  registered control code of the accepted op.
- zero  out  1  result == 0.
- branch_taken  out  1  beq: zero; bne: !zero; else 0.
- illegal  out  1  undefined decode; result forced 0.

Behaviour:
- Reset values: out_valid=0, result=0, alu_ctrl=0, zero=0 (tracks result=0 but forced 0 while out_valid=0), branch_taken=0, illegal=0, state=IDLE. Reset mid-operation aborts the op and drops it.
- Control codes:
  - 0000 and, 0001 or, 0010 add/lw/sw/addi, 0011 sll, 0100 slt, 0101 sltu.
  - 0110 sub/beq, 0111 xor, 1000 srl, 1001 jal, 1010 sra.
  - 1011 rem, 1101 div, 1110 mul, 1111 bne.
- Decode rules:
  - R-type: key is {funct7[5],funct3}. funct7[0]=1 with funct3 000/100/110 selects mul/div/rem.
  - I-type: keyed on funct3 only.
  - Branch funct3 other than 000/001, R-type keys not listed above, and 1100 all raise illegal and complete in 1 cycle.
- Shifts use src_b[log2(XLEN)-1:0].
- jal result = src_a + 4.
- slt/sltu result = 1 or 0, zero-extended.
- Handshake: accept when in_valid && in_ready; operands and control are captured on that edge.
- FSM states IDLE, EXEC, MUL, DIV, FIX, DONE:
  - IDLE->EXEC on single-cycle accept. EXEC->DONE after 1 cycle, so out_valid rises 1 cycle after the accept edge.
  - IDLE->MUL or IDLE->DIV on mul/div/rem accept. Counter loads XLEN; one bit per cycle; at 0 go to FIX.
  - FIX applies sign correction, then ->DONE. out_valid rises XLEN+1 cycles after the accept edge.
  - DONE->IDLE when out_ready=1. If out_ready=0, result and flags hold stable.
  - in_ready=0 in every state except IDLE. No accept on the same edge the result is consumed; back-to-back issue costs one IDLE cycle.
- mul: low XLEN bits of the product.
- div/rem: signed. Operands are converted to magnitudes; the quotient is negated if the signs differ; the remainder takes the sign of the dividend.
- div by zero: quotient all ones, rem = src_a.
- Overflow (most-negative / -1): quotient = most-negative, rem = 0.

Optional Feature:
- ALU_EARLY_OUT_EN.
- Defined:
  - mul with either operand 0 -> result 0, latency 1.
  - div/rem with divisor 0 or the overflow case -> special result, latency 1.
  - These go IDLE->EXEC->DONE.
- Undefined: every mul/div/rem takes fixed latency XLEN+1 and special cases fall out of the normal iteration plus FIX.

Decomposition:
- Package alu_pkg holds:
  - CTRL_W and all control code localparams.
  - aluop encodings.
  - FSM state typedef/localparams.
- Sub-module alu_ctrl_decode: combinational aluop/funct7/funct3/jump -> {ctrl, illegal, is_multicycle}.

Test Plan:
1. aluop=10, funct7=0x00, funct3=000, a=5, b=7 -> out_valid 1 cycle after accept, result=12, alu_ctrl=0010.
2. aluop=01, funct3=001, a=b=9 -> result=0, zero=1, branch_taken=0, alu_ctrl=1111.
3. aluop=10, funct7=0x01, funct3=000, a=-3, b=7 -> result=0xFFFFFFEB after 33 cycles; in_ready low throughout.
4. div a=-7, b=2 -> -3; rem same operands -> -1. div a=5, b=0 -> 0xFFFFFFFF; rem a=5, b=0 -> 5. div 0x80000000 / -1 -> 0x80000000. With ALU_EARLY_OUT_EN, the zero-divisor cases take latency 1.
5. out_ready held low 4 cycles in DONE -> result stable, no new accept. Reset asserted mid-div at cycle 10 -> next cycle out_valid=0, in_ready=1.
6. aluop=10, funct7=0x20, funct3=010 -> illegal=1, result=0, latency 1.
